// File: rtl/val_ready_fifo.sv
// val_ready_fifo: parameterised synchronous first-word-fall-through FIFO with
// valid/ready handshakes on both sides. The upstream ready and downstream valid
// flags come straight from registers, so no combinational path runs from
// ready_i to ready_o.
module val_ready_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] data_in,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_out,
    output logic [CW-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          ready_r;
    logic          valid_r;

    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] count_nxt_s;

    // Handshake qualification uses only the registered flags, so a full FIFO
    // ignores valid_i and an empty FIFO ignores ready_i.
    assign push_s = valid_i & ready_r;
    assign pop_s  = valid_r & ready_i;

    // Next occupancy: push and pop on the same edge cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array: cleared on reset, written at wr_ptr on an accepted push.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy and the registered ready/valid flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_nxt_s;
            ready_r <= (count_nxt_s != CW'(DEPTH));
            valid_r <= (count_nxt_s != CW'(0));
        end
    end

    // Head word is presented straight from storage (fall-through); while the
    // FIFO is empty it shows whatever stale word sits at rd_ptr.
    assign data_out = mem_r[rd_ptr_r];
    assign ready_o  = ready_r;
    assign valid_o  = valid_r;
    assign count_o  = count_r;

endmodule
